// File: rtl/div_signed_wrapper_if.sv
// div_signed_wrapper_if
//   Request/result bundle between an issuing pipeline and div_signed_wrapper.
//   Request : i_valid, i_op (00=DIV 01=DIVU 10=REM 11=REMU), i_rs1, i_rs2, i_rd
//   Result  : o_valid, o_result, o_rd (registered inside the divider wrapper)
//   master  : issuer/writeback side; slave : divider wrapper side.
interface div_signed_wrapper_if #(
    parameter int unsigned RD_W = 5
) ();
    logic            i_valid;
    logic [1:0]      i_op;
    logic [31:0]     i_rs1;
    logic [31:0]     i_rs2;
    logic [RD_W-1:0] i_rd;
    logic            o_valid;
    logic [31:0]     o_result;
    logic [RD_W-1:0] o_rd;

    modport master (
        output i_valid, i_op, i_rs1, i_rs2, i_rd,
        input  o_valid, o_result, o_rd
    );

    modport slave (
        input  i_valid, i_op, i_rs1, i_rs2, i_rd,
        output o_valid, o_result, o_rd
    );
endinterface

// File: rtl/div_signed_wrapper.sv
// div_signed_wrapper
//   Signed/unsigned front- and back-end around an unsigned pipelined divider
//   core, implementing RISC-V DIV, DIVU, REM and REMU.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     bus (slave)       : op request in, registered result + rd out
//     o_core_dividend/o_core_divisor   : operand magnitudes to the core (comb)
//     i_core_quotient/i_core_remainder : core results, CORE_LATENCY cycles later
//     o_inflight        : valid ops in tag pipeline plus output register
//     i_check_rd        : register index probed for hazards
//     o_rd_pending      : some in-flight op writes i_check_rd (never for x0)
//   Optional macro DIV_EXC_FLAGS_EN adds o_div_zero / o_div_ovf, registered
//   alongside o_valid and forced low when no result is presented.
module div_signed_wrapper #(
    parameter int unsigned CORE_LATENCY = 7,
    parameter int unsigned RD_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    div_signed_wrapper_if.slave bus,
    output logic [31:0]      o_core_dividend,
    output logic [31:0]      o_core_divisor,
    input  logic [31:0]      i_core_quotient,
    input  logic [31:0]      i_core_remainder,
    output logic [3:0]       o_inflight,
    input  logic [RD_W-1:0]  i_check_rd,
    output logic             o_rd_pending
`ifdef DIV_EXC_FLAGS_EN
    ,
    output logic             o_div_zero,
    output logic             o_div_ovf
`endif
);
    localparam int unsigned LAST = CORE_LATENCY - 1;

    logic is_signed, neg_a, neg_b, dz_in;

    // Operand conditioning; -0x80000000 wraps to 0x80000000, which the
    // unsigned core treats as the correct magnitude.
    always_comb begin
        is_signed       = ~bus.i_op[0];
        neg_a           = is_signed & bus.i_rs1[31];
        neg_b           = is_signed & bus.i_rs2[31];
        dz_in           = (bus.i_rs2 == '0);
        o_core_dividend = neg_a ? (32'd0 - bus.i_rs1) : bus.i_rs1;
        o_core_divisor  = neg_b ? (32'd0 - bus.i_rs2) : bus.i_rs2;
    end

    // Tag pipeline, stage k aligned with core stage k.
    logic [CORE_LATENCY-1:0] t_valid, t_rem, t_sq, t_sr, t_dz;
    logic [RD_W-1:0]         t_rd [CORE_LATENCY];

    always_ff @(posedge clk) begin
        t_rem   <= {t_rem[LAST-1:0], bus.i_op[1]};
        t_sq    <= {t_sq[LAST-1:0], neg_a ^ neg_b};
        t_sr    <= {t_sr[LAST-1:0], neg_a};
        t_dz    <= {t_dz[LAST-1:0], dz_in};
        t_rd[0] <= bus.i_rd;
        for (int unsigned i = 1; i < CORE_LATENCY; i++) begin
            t_rd[i] <= t_rd[i-1];
        end
    end

`ifdef DIV_EXC_FLAGS_EN
    logic                    ovf_in;
    logic [CORE_LATENCY-1:0] t_ovf;

    always_comb begin
        ovf_in = is_signed & (bus.i_rs1 == 32'h8000_0000) & (bus.i_rs2 == 32'hFFFF_FFFF);
    end

    always_ff @(posedge clk) begin
        t_ovf <= {t_ovf[LAST-1:0], ovf_in};
    end
`endif

    // Result fix-up from the last tag and the core outputs.
    logic [31:0] q_fix, r_fix, res_next;

    always_comb begin
        if (t_dz[LAST]) begin
            q_fix = '1;
        end else if (t_sq[LAST]) begin
            q_fix = 32'd0 - i_core_quotient;
        end else begin
            q_fix = i_core_quotient;
        end
        r_fix    = t_sr[LAST] ? (32'd0 - i_core_remainder) : i_core_remainder;
        res_next = t_rem[LAST] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_valid      <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_result <= '0;
            bus.o_rd     <= '0;
            o_inflight   <= '0;
`ifdef DIV_EXC_FLAGS_EN
            o_div_zero   <= 1'b0;
            o_div_ovf    <= 1'b0;
`endif
        end else begin
            t_valid     <= {t_valid[LAST-1:0], bus.i_valid};
            bus.o_valid <= t_valid[LAST];
            if (t_valid[LAST]) begin
                bus.o_result <= res_next;
                bus.o_rd     <= t_rd[LAST];
            end
            // Entry and retirement in the same cycle cancel out.
            o_inflight <= o_inflight + 4'(bus.i_valid) - 4'(bus.o_valid);
`ifdef DIV_EXC_FLAGS_EN
            o_div_zero <= t_valid[LAST] & t_dz[LAST];
            o_div_ovf  <= t_valid[LAST] & t_ovf[LAST];
`endif
        end
    end

    // Hazard probe over every tag stage and the output register.
    logic hit;

    always_comb begin
        hit = bus.o_valid & (bus.o_rd == i_check_rd);
        for (int unsigned i = 0; i < CORE_LATENCY; i++) begin
            hit = hit | (t_valid[i] & (t_rd[i] == i_check_rd));
        end
        o_rd_pending = hit & (i_check_rd != '0);
    end
endmodule

// File: tb/tb_div_signed_wrapper.sv
// tb_div_signed_wrapper
//   Scoreboard bench for div_signed_wrapper with a behavioural 7-cycle
//   unsigned divider core. Directed vectors carry hand-computed results.
module tb_div_signed_wrapper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] core_dividend, core_divisor, core_q, core_r;
    logic [3:0]  inflight;
    logic [4:0]  check_rd;
    logic        rd_pending;
`ifdef DIV_EXC_FLAGS_EN
    logic        div_zero, div_ovf;
`endif

    div_signed_wrapper_if #(.RD_W(5)) bus ();

    div_signed_wrapper #(.CORE_LATENCY(7), .RD_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .o_core_dividend  (core_dividend),
        .o_core_divisor   (core_divisor),
        .i_core_quotient  (core_q),
        .i_core_remainder (core_r),
        .o_inflight       (inflight),
        .i_check_rd       (check_rd),
        .o_rd_pending     (rd_pending)
`ifdef DIV_EXC_FLAGS_EN
        ,
        .o_div_zero       (div_zero),
        .o_div_ovf        (div_ovf)
`endif
    );

    // Behavioural core: operands travel 7 register stages, result is
    // combinational from the last stage. Divide by zero returns r = dividend.
    logic [31:0] cp_a [7];
    logic [31:0] cp_b [7];

    always_ff @(posedge clk) begin
        cp_a[0] <= core_dividend;
        cp_b[0] <= core_divisor;
        for (int i = 1; i < 7; i++) begin
            cp_a[i] <= cp_a[i-1];
            cp_b[i] <= cp_b[i-1];
        end
    end

    always_comb begin
        core_q = '1;
        core_r = cp_a[6];
        if (cp_b[6] != 32'd0) begin
            core_q = cp_a[6] / cp_b[6];
            core_r = cp_a[6] % cp_b[6];
        end
    end

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        dz;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   pushed = 0;
    int   popped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=%h/rd%0d required=none", bus.o_result, bus.o_rd);
            end else begin
                e = sb.pop_front();
                popped++;
                chk("result", bus.o_result, e.res);
                chk("rd", 32'(bus.o_rd), 32'(e.rd));
`ifdef DIV_EXC_FLAGS_EN
                chk("div_zero", 32'(div_zero), 32'(e.dz));
                chk("div_ovf", 32'(div_ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res,
                         input logic dz, input logic ovf);
        exp_t e;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_rs1   = a;
        bus.i_rs2   = b;
        bus.i_rd    = rd;
        e.res = res;
        e.rd  = rd;
        e.dz  = dz;
        e.ovf = ovf;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && inflight == 4'd0 && bus.o_valid == 1'b0) break;
            @(negedge clk);
        end
        chk(name, 32'(inflight), 32'd0);
        chk({name, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    initial begin : main
        int lat;
        int vcount, first_v, last_v, peak;

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_op    = DIV;
        bus.i_rs1   = '0;
        bus.i_rs2   = '0;
        bus.i_rd    = '0;
        check_rd    = '0;

        #12;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_rd", 32'(bus.o_rd), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
`ifdef DIV_EXC_FLAGS_EN
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_div_ovf", 32'(div_ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Latency of a single op: -7 / 2 = -3
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        lat = 1;
        while (bus.o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 32'(lat), 32'd8);
        wait_drain("drain_latency");

        // Signed/unsigned, overflow and divide-by-zero vectors
        issue(REM,  32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(DIVU, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'h7FFF_FFFC, 1'b0, 1'b0);
        issue(REMU, 32'd100,       32'd7,         5'd8,  32'd2,         1'b0, 1'b0);
        issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1'b0, 1'b1);
        issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1'b0, 1'b1);
        issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1'b0, 1'b0);
        issue(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b0, 1'b0);
        issue(DIV,  32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(DIVU, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(REM,  32'hFFFF_FFFB, 32'd0,         5'd15, 32'hFFFF_FFFB, 1'b1, 1'b0);
        issue(REMU, 32'd9,         32'd0,         5'd16, 32'd9,         1'b1, 1'b0);
        idle();
        wait_drain("drain_vectors");

        // Back-to-back burst, rd = 1..8
        issue(DIV,  32'd7,         32'hFFFF_FFFE, 5'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        issue(REM,  32'd7,         32'hFFFF_FFFE, 5'd2, 32'd1,         1'b0, 1'b0);
        issue(DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd3, 32'd3,         1'b0, 1'b0);
        issue(REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(DIV,  32'h8000_0000, 32'd3,         5'd5, 32'hD555_5556, 1'b0, 1'b0);
        issue(REM,  32'h8000_0000, 32'd3,         5'd6, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(DIVU, 32'd1000,      32'd10,        5'd7, 32'd100,       1'b0, 1'b0);
        issue(REMU, 32'hFFFF_FFFF, 32'd16,        5'd8, 32'd15,        1'b0, 1'b0);
        vcount  = 0;
        first_v = -1;
        last_v  = -1;
        peak    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            if (int'(inflight) > peak) peak = int'(inflight);
            if (bus.o_valid === 1'b1) begin
                vcount++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        chk("burst_count", 32'(vcount), 32'd8);
        chk("burst_span", 32'(last_v - first_v), 32'd7);
        chk("burst_peak", 32'(peak), 32'd8);
        wait_drain("drain_burst");

        // Hazard probe
        check_rd = 5'd3;
        @(negedge clk);
        #1 chk("pending_idle", 32'(rd_pending), 32'd0);
        issue(DIVU, 32'd50, 32'd5, 5'd3, 32'd10, 1'b0, 1'b0);
        #1 chk("pending_issue", 32'(rd_pending), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1 chk("pending_inflight", 32'(rd_pending), 32'd1);
        end
        @(negedge clk);
        #1 chk("pending_after", 32'(rd_pending), 32'd0);
        check_rd = 5'd0;
        issue(DIVU, 32'd50, 32'd5, 5'd0, 32'd10, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1 chk("pending_x0", 32'(rd_pending), 32'd0);
        end
        wait_drain("drain_pending");

        // Asynchronous reset with ops in flight
        issue(DIVU, 32'd21, 32'd3, 5'd20, 32'd7, 1'b0, 1'b0);
        issue(DIVU, 32'd22, 32'd2, 5'd21, 32'd11, 1'b0, 1'b0);
        issue(REMU, 32'd23, 32'd5, 5'd22, 32'd3, 1'b0, 1'b0);
        idle();
        #1 chk("pre_rst_inflight", 32'(inflight), 32'd3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("async_rst_inflight", 32'(inflight), 32'd0);
        pushed = pushed - sb.size();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(DIV, 32'hFFFF_FF9C, 32'd7, 5'd23, 32'hFFFF_FFF2, 1'b0, 1'b0);
        idle();
        wait_drain("drain_post_rst");

        chk("result_count", 32'(popped), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
